// File: rtl/noc_port_arbiter.sv
// -----------------------------------------------------------------------------
// noc_port_arbiter
//   Round-robin arbiter for one mesh-router output link. Up to NUM_REQ input
//   stages compete for a single FLIT_W-bit link; at most one flit per cycle is
//   granted and registered onto the link. Downstream flow control is
//   credit-based: each grant consumes a credit, each credit_return refunds one.
//
//   Ports
//     clk, rst_n      clock (rising edge) and async active-low reset
//     en              1 = grants allowed (takes effect from the next cycle)
//     req_valid       per-requester flit-present flags
//     req_flit        packed flits, requester i at [i*FLIT_W +: FLIT_W]
//     req_ready       one-hot grant (combinational), flit consumed this cycle
//     out_valid       one-cycle pulse: out_flit is being sent downstream
//     out_flit        registered winning flit
//     credit_return   downstream released one buffer slot
//     credit_cnt      credits currently available
//     grant_id        index of the most recently granted requester
//     credit_err      sticky: a credit was returned while already at CREDITS
// -----------------------------------------------------------------------------
module noc_port_arbiter #(
    parameter int unsigned NUM_REQ = 5,
    parameter int unsigned FLIT_W  = 11,
    parameter int unsigned CREDITS = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             en,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*FLIT_W-1:0]        req_flit,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic                             out_valid,
    output logic [FLIT_W-1:0]                out_flit,
    input  logic                             credit_return,
    output logic [$clog2(CREDITS+1)-1:0]     credit_cnt,
    output logic [$clog2(NUM_REQ)-1:0]       grant_id,
    output logic                             credit_err
);

    localparam int unsigned CNT_W = $clog2(CREDITS + 1);
    localparam int unsigned ID_W  = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]    credit_cnt_q, credit_cnt_d;
    logic                credit_err_q, credit_err_d;
    logic                out_valid_q, out_valid_d;
    logic [FLIT_W-1:0]   out_flit_q, out_flit_d;
    logic [ID_W-1:0]     grant_id_q, grant_id_d;

    logic                win_found;
    logic [ID_W-1:0]     win_idx;
    logic                grant_c;

    // ---------------------------------------------------------------------
    // Round-robin search: first valid requester starting at ptr_q, wrapping.
    // ---------------------------------------------------------------------
    always_comb begin : p_search
        int unsigned j;
        win_found = 1'b0;
        win_idx   = '0;
        j         = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            j = 32'(ptr_q) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!win_found && req_valid[ID_W'(j)]) begin
                win_found = 1'b1;
                win_idx   = ID_W'(j);
            end
        end
    end

    // ---------------------------------------------------------------------
    // FSM: state register.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state. The registered state reflects the en sampled at the
    // previous edge together with the credit count that is now registered.
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = IDLE;
        end else if (credit_cnt_d == '0) begin
            state_d = STALL;
        end else begin
            state_d = RUN;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: outputs. Grants only in RUN, so a same-cycle credit_return can
    // never unblock a STALL; reset forces IDLE and therefore req_ready=0.
    // ---------------------------------------------------------------------
    always_comb begin
        grant_c   = 1'b0;
        req_ready = '0;
        if (state_q == RUN && win_found) begin
            grant_c   = 1'b1;
            req_ready = NUM_REQ'(1) << win_idx;
        end
    end

    // ---------------------------------------------------------------------
    // Link register, pointer and grant id update.
    // ---------------------------------------------------------------------
    always_comb begin
        out_valid_d = 1'b0;
        out_flit_d  = out_flit_q;
        grant_id_d  = grant_id_q;
        ptr_d       = ptr_q;
        if (grant_c) begin
            out_valid_d = 1'b1;
            out_flit_d  = req_flit[32'(win_idx)*FLIT_W +: FLIT_W];
            grant_id_d  = win_idx;
            if (32'(win_idx) == NUM_REQ - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = win_idx + ID_W'(1);
            end
        end
    end

    // ---------------------------------------------------------------------
    // Credit counter: grant consumes, return refunds, both cancel out.
    // A lone return at full count is dropped and flagged.
    // ---------------------------------------------------------------------
    always_comb begin
        credit_cnt_d = credit_cnt_q;
        credit_err_d = credit_err_q;
        unique case ({grant_c, credit_return})
            2'b10: credit_cnt_d = credit_cnt_q - CNT_W'(1);
            2'b01: begin
                if (credit_cnt_q == CNT_W'(CREDITS)) begin
                    credit_err_d = 1'b1;
                end else begin
                    credit_cnt_d = credit_cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q        <= '0;
            credit_cnt_q <= CNT_W'(CREDITS);
            credit_err_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_flit_q   <= '0;
            grant_id_q   <= '0;
        end else begin
            ptr_q        <= ptr_d;
            credit_cnt_q <= credit_cnt_d;
            credit_err_q <= credit_err_d;
            out_valid_q  <= out_valid_d;
            out_flit_q   <= out_flit_d;
            grant_id_q   <= grant_id_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_flit   = out_flit_q;
    assign credit_cnt = credit_cnt_q;
    assign credit_err = credit_err_q;
    assign grant_id   = grant_id_q;

endmodule

// File: tb/tb_noc_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_noc_port_arbiter
//   Directed scenarios plus randomized traffic, all compared against a
//   behavioural arbiter/credit model held in the bench.
// -----------------------------------------------------------------------------
module tb_noc_port_arbiter;

    localparam int unsigned NUM_REQ = 5;
    localparam int unsigned FLIT_W  = 11;
    localparam int unsigned CREDITS = 4;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned ID_W    = 3;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      en;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*FLIT_W-1:0] req_flit;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      out_valid;
    logic [FLIT_W-1:0]         out_flit;
    logic                      credit_return;
    logic [CNT_W-1:0]          credit_cnt;
    logic [ID_W-1:0]           grant_id;
    logic                      credit_err;

    always #5 clk = ~clk;

    noc_port_arbiter #(
        .NUM_REQ (NUM_REQ),
        .FLIT_W  (FLIT_W),
        .CREDITS (CREDITS)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .req_valid     (req_valid),
        .req_flit      (req_flit),
        .req_ready     (req_ready),
        .out_valid     (out_valid),
        .out_flit      (out_flit),
        .credit_return (credit_return),
        .credit_cnt    (credit_cnt),
        .grant_id      (grant_id),
        .credit_err    (credit_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit              m_en_q;
    int              m_cnt;
    int              m_ptr;
    int              m_gid;
    bit              m_ov;
    bit              m_err;
    logic [FLIT_W-1:0] m_flit;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_en_q = 1'b0;
        m_cnt  = CREDITS;
        m_ptr  = 0;
        m_gid  = 0;
        m_ov   = 1'b0;
        m_err  = 1'b0;
        m_flit = '0;
    endtask

    // Winner per the round-robin rule, or -1 when nothing may be granted.
    function automatic int model_winner();
        if (!m_en_q || m_cnt == 0) return -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            int i;
            i = (m_ptr + k) % NUM_REQ;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    task automatic check_regs();
        check("out_valid",  32'(out_valid),  32'(m_ov));
        check("out_flit",   32'(out_flit),   32'(m_flit));
        check("grant_id",   32'(grant_id),   32'(m_gid));
        check("credit_cnt", 32'(credit_cnt), 32'(m_cnt));
        check("credit_err", 32'(credit_err), 32'(m_err));
    endtask

    // One clock cycle: inputs are already applied (called just after negedge).
    task automatic step();
        int w;
        logic [NUM_REQ-1:0] exp_rdy;
        #1;
        w = model_winner();
        exp_rdy = (w < 0) ? '0 : (NUM_REQ'(1) << w);
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check_regs();
        @(posedge clk);
        if (w >= 0) begin
            m_ov   = 1'b1;
            m_flit = req_flit[w*FLIT_W +: FLIT_W];
            m_gid  = w;
            m_ptr  = (w + 1) % NUM_REQ;
        end else begin
            m_ov = 1'b0;
        end
        if (w >= 0 && !credit_return) begin
            m_cnt = m_cnt - 1;
        end else if (w < 0 && credit_return) begin
            if (m_cnt == CREDITS) m_err = 1'b1;
            else                  m_cnt = m_cnt + 1;
        end
        m_en_q = en;
        @(negedge clk);
    endtask

    // Asynchronous reset asserted mid-cycle, checked before any clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        check("rst_out_valid",  32'(out_valid),  32'(0));
        check("rst_req_ready",  32'(req_ready),  32'(0));
        check("rst_credit_cnt", 32'(credit_cnt), 32'(CREDITS));
        check("rst_credit_err", 32'(credit_err), 32'(0));
        check("rst_grant_id",   32'(grant_id),   32'(0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic rand_flits();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_flit[i*FLIT_W +: FLIT_W] = FLIT_W'($urandom);
        end
    endtask

    initial begin
        int gids[$];
        int pulses;
        logic [FLIT_W-1:0] fl3;
        int exp_seq[7];

        rst_n = 1'b0; en = 1'b0; req_valid = '0; req_flit = '0; credit_return = 1'b0;
        model_reset();
        @(negedge clk);

        // Reset mid-operation with requests pending
        en = 1'b1; req_valid = '1; rand_flits();
        do_reset();

        // Round-robin fairness with credits returned as flits leave
        en = 1'b1; req_valid = '1; rand_flits(); credit_return = 1'b0;
        exp_seq = '{0, 1, 2, 3, 4, 0, 1};
        repeat (10) begin
            credit_return = out_valid;
            if (out_valid) gids.push_back(int'(grant_id));
            step();
        end
        check("rr_count", 32'(gids.size() >= 7), 32'(1));
        for (int k = 0; k < 7 && k < gids.size(); k++) begin
            check("rr_seq", 32'(gids[k]), 32'(exp_seq[k]));
        end

        // Credit exhaustion with a single requester
        credit_return = 1'b0;
        do_reset();
        en = 1'b1; req_valid = 5'b00001; rand_flits(); credit_return = 1'b0;
        pulses = 0;
        repeat (8) begin
            step();
            if (out_valid) pulses++;
        end
        check("exh_pulses", 32'(pulses), 32'(4));
        check("exh_cnt", 32'(credit_cnt), 32'(0));
        check("exh_ready", 32'(req_ready), 32'(0));
        credit_return = 1'b1;
        step();
        credit_return = 1'b0;
        check("exh_refund", 32'(credit_cnt), 32'(1));
        step();
        check("exh_regrant", 32'(out_valid), 32'(1));
        check("exh_cnt0", 32'(credit_cnt), 32'(0));
        step();

        // Grant and credit return in the same cycle
        do_reset();
        en = 1'b1; req_valid = '0; rand_flits();
        step();
        req_valid = 5'b00001;
        step();
        step();
        check("sim_cnt_pre", 32'(credit_cnt), 32'(2));
        fl3 = FLIT_W'($urandom);
        req_flit[3*FLIT_W +: FLIT_W] = fl3;
        req_valid = 5'b01000; credit_return = 1'b1;
        step();
        credit_return = 1'b0; req_valid = '0;
        check("sim_cnt", 32'(credit_cnt), 32'(2));
        check("sim_flit", 32'(out_flit), 32'(fl3));
        check("sim_gid", 32'(grant_id), 32'(3));
        step();

        // Credit overflow is sticky
        do_reset();
        en = 1'b0; req_valid = '0; credit_return = 1'b1;
        step();
        credit_return = 1'b0;
        check("ovf_err", 32'(credit_err), 32'(1));
        check("ovf_cnt", 32'(credit_cnt), 32'(CREDITS));
        en = 1'b1; req_valid = '1; rand_flits();
        repeat (6) begin
            credit_return = out_valid;
            step();
        end
        check("ovf_sticky", 32'(credit_err), 32'(1));

        // Pointer skip and wrap, then en dropping with a flit in flight
        credit_return = 1'b0;
        do_reset();
        en = 1'b1; req_valid = '0; rand_flits();
        step();
        req_valid = 5'b00100; credit_return = out_valid;
        step();
        check("ptr_g2", 32'(grant_id), 32'(2));
        req_valid = 5'b00101; credit_return = out_valid;
        step();
        check("ptr_g0", 32'(grant_id), 32'(0));
        credit_return = out_valid;
        step();
        check("ptr_g2b", 32'(grant_id), 32'(2));
        req_valid = 5'b10001; credit_return = out_valid;
        step();
        check("ptr_g4", 32'(grant_id), 32'(4));
        credit_return = out_valid; en = 1'b0;
        step();
        check("wrap_g0", 32'(grant_id), 32'(0));
        check("en_pending", 32'(out_valid), 32'(1));
        credit_return = out_valid;
        step();
        check("en_stop", 32'(out_valid), 32'(0));
        credit_return = 1'b0;
        step();

        // Randomized traffic with occasional asynchronous resets
        repeat (400) begin
            en            = ($urandom_range(0, 9) != 0);
            req_valid     = NUM_REQ'($urandom);
            credit_return = ($urandom_range(0, 2) == 0);
            rand_flits();
            if ($urandom_range(0, 99) == 0) do_reset();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
